// File: rtl/conv_maxpool_2x2.sv
// conv_maxpool_2x2: 2x2 stride-2 signed max pooling (optional ReLU) over a streamed
// N x N conv output frame, using a single half-row line buffer.
module conv_maxpool_2x2 #(
   parameter int DW      = 16,
   parameter int MAX_N   = 32,
   parameter int NW      = 6,
   parameter int RELU_EN = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [NW-1:0] n_dim,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          done,
   output logic          busy
);
   localparam int AW = $clog2(MAX_N / 2);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               state_q, state_d;
   logic [NW-1:0]        n_q, n_d, c_q, c_d, r_q, r_d, lim;
   logic signed [DW-1:0] h_q, h_d, out_data_q, out_data_d;
   logic signed [DW-1:0] din, lb_rd, m, pooled, res;
   logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                 acc, keep, c_end, lb_we;
   logic [AW-1:0]        idx;
   logic signed [DW-1:0] line_buf_q [MAX_N/2];

   always_comb begin
      din         = $signed(in_data);
      lim         = {n_q[NW-1:1], 1'b0} - NW'(1);
      idx         = AW'(c_q >> 1);
      lb_rd       = line_buf_q[idx];
      m           = (din > h_q) ? din : h_q;
      pooled      = (m > lb_rd) ? m : lb_rd;
      res         = (RELU_EN != 0 && pooled < 0) ? '0 : pooled;
      acc         = state_q == RUN && in_valid;
      // trailing odd row/column lies outside every 2x2 window
      keep        = acc && c_q <= lim && r_q <= lim;
      c_end       = c_q == n_q - NW'(1);
      lb_we       = keep && c_q[0] && !r_q[0];
      state_d     = state_q == IDLE ? (start ? (n_dim >= NW'(2) ? RUN : FIN) : IDLE) :
                    state_q == RUN  ? ((acc && c_end && r_q == n_q - NW'(1)) ? FIN : RUN) : IDLE;
      n_d         = (state_q == IDLE && start) ? n_dim : n_q;
      c_d         = state_q == IDLE ? '0 : acc ? (c_end ? '0 : c_q + NW'(1)) : c_q;
      r_d         = state_q == IDLE ? '0 : (acc && c_end) ? r_q + NW'(1) : r_q;
      h_d         = (keep && !c_q[0]) ? din : h_q;
      out_valid_d = keep && c_q[0] && r_q[0];
      out_data_d  = out_valid_d ? res : out_data_q;
      out_last_d  = out_valid_d && c_q == lim && r_q == lim;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         n_q         <= '0;
         c_q         <= '0;
         r_q         <= '0;
         h_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         c_q         <= c_d;
         r_q         <= r_d;
         h_q         <= h_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // even rows are always written before the odd row reads them, so no reset is needed
   always_ff @(posedge clk) begin
      if (lb_we) line_buf_q[idx] <= m;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign done      = state_q == FIN;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// tb_conv_maxpool_2x2: drives plain and ReLU instances with directed and random frames,
// checking against a whole-frame pooling model.
module tb_conv_maxpool_2x2;
   localparam int DW = 16;
   localparam int NW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [NW-1:0] n_dim = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid0, out_last0, done0, busy0;
   logic          out_valid1, out_last1, done1, busy1;
   logic [DW-1:0] out_data0, out_data1;

   int checks = 0;
   int errors = 0;
   int s [32][32];
   int q0[$], q1[$], ql0[$], ql1[$];
   bit exp_done = 1'b0;

   conv_maxpool_2x2 #(.DW(DW), .MAX_N(32), .NW(NW), .RELU_EN(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .n_dim(n_dim), .in_valid(in_valid),
      .in_data(in_data), .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0),
      .done(done0), .busy(busy0));

   conv_maxpool_2x2 #(.DW(DW), .MAX_N(32), .NW(NW), .RELU_EN(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .n_dim(n_dim), .in_valid(in_valid),
      .in_data(in_data), .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1),
      .done(done1), .busy(busy1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic observe();
      if (out_valid0) begin
         if (q0.size() == 0) chk("spurious0", 1, 0);
         else begin
            chk("data0", $signed(out_data0), q0.pop_front());
            chk("last0", int'(out_last0), ql0.pop_front());
         end
      end else chk("last_novalid0", int'(out_last0), 0);
      if (out_valid1) begin
         if (q1.size() == 0) chk("spurious1", 1, 0);
         else begin
            chk("data1", $signed(out_data1), q1.pop_front());
            chk("last1", int'(out_last1), ql1.pop_front());
         end
      end else chk("last_novalid1", int'(out_last1), 0);
      chk("done0", int'(done0), int'(exp_done));
      chk("done1", int'(done1), int'(exp_done));
      if (exp_done) chk("pending_at_done", q0.size() + q1.size(), 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      observe();
   endtask

   task automatic build_model(input int n);
      int p, mx;
      p = n / 2;
      for (int i = 0; i < p; i++)
         for (int j = 0; j < p; j++) begin
            mx = s[2*i][2*j];
            if (s[2*i][2*j+1] > mx) mx = s[2*i][2*j+1];
            if (s[2*i+1][2*j] > mx) mx = s[2*i+1][2*j];
            if (s[2*i+1][2*j+1] > mx) mx = s[2*i+1][2*j+1];
            q0.push_back(mx);
            q1.push_back(mx < 0 ? 0 : mx);
            ql0.push_back(int'(i == p - 1 && j == p - 1));
            ql1.push_back(int'(i == p - 1 && j == p - 1));
         end
   endtask

   task automatic idle_cycle(input bit sstart);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      start    = sstart ? 1'($urandom_range(0, 1)) : 1'b0;
      n_dim    = NW'($urandom_range(0, 31));
      step();
      start    = 1'b0;
   endtask

   // gmode 0: back-to-back, 1: idle cycle between samples plus bursts, 2: random gaps
   task automatic frame(input int n, input int nsamp, input int gmode, input bit sstart);
      if (n >= 2) build_model(n);
      start    = 1'b1;
      n_dim    = NW'(n);
      exp_done = (n < 2);
      step();
      start    = 1'b0;
      exp_done = 1'b0;
      chk("busy_start", int'(busy0), 1);
      if (n < 2) begin
         step();
         chk("busy_after_tiny", int'(busy0), 0);
      end else begin
         for (int k = 0; k < nsamp; k++) begin
            if (gmode == 1) begin
               idle_cycle(sstart);
               if ($urandom_range(0, 4) == 0)
                  repeat ($urandom_range(1, 6)) idle_cycle(sstart);
            end else if (gmode == 2) begin
               while ($urandom_range(0, 2) == 0) idle_cycle(sstart);
            end
            in_valid = 1'b1;
            in_data  = DW'(s[k / n][k % n]);
            n_dim    = NW'($urandom_range(0, 31));
            exp_done = (k == n * n - 1);
            step();
            exp_done = 1'b0;
            in_valid = 1'b0;
         end
         if (nsamp == n * n) begin
            step();
            chk("busy_end", int'(busy0), 0);
            chk("leftover", q0.size() + q1.size(), 0);
         end
      end
   endtask

   task automatic fill_seq(input int n);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) s[r][c] = r * n + c;
   endtask

   task automatic fill_rand(input int n);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            s[r][c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) - 2
                                                  : $urandom_range(0, 65535) - 32768;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      step();
      step();
      chk("rst_valid", int'(out_valid0), 0);
      chk("rst_data", int'(out_data0), 0);
      chk("rst_last", int'(out_last0), 0);
      chk("rst_busy", int'(busy0), 0);
      reset = 1'b0;
      repeat (3) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom);
         step();
      end
      in_valid = 1'b0;
      fill_seq(4);
      frame(4, 16, 0, 1'b0);
      fill_seq(5);
      frame(5, 25, 0, 1'b0);
      s[0][0] = -5; s[0][1] = -3; s[1][0] = -7; s[1][1] = -9;
      frame(2, 4, 0, 1'b0);
      fill_seq(4);
      frame(4, 16, 1, 1'b0);
      fill_seq(4);
      frame(4, 6, 0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      q0.delete(); q1.delete(); ql0.delete(); ql1.delete();
      chk("busy_after_reset", int'(busy0), 0);
      repeat (3) step();
      s[0][0] = 1; s[0][1] = 2; s[1][0] = 3; s[1][1] = 4;
      frame(2, 4, 0, 1'b0);
      frame(1, 0, 0, 1'b0);
      frame(0, 0, 0, 1'b0);
      fill_seq(4);
      frame(4, 16, 2, 1'b1);
      for (int t = 0; t < 24; t++) begin
         n = (t == 0) ? 32 : (t == 1) ? 31 : $urandom_range(2, 11);
         fill_rand(n);
         frame(n, n * n, $urandom_range(0, 2), 1'b1);
         repeat ($urandom_range(0, 3)) idle_cycle(1'b0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
